// File: rtl/modexp_pkg.sv
// Shared definitions for the 255-bit modular exponentiation controller.
//   FE_W          : field-element width in bits
//   P             : field prime 2^255 - 19
//   EXP_W_DEFAULT : default exponent width in bits
//   state_e       : controller FSM states
package modexp_pkg;

  localparam int unsigned FE_W          = 255;
  localparam int unsigned EXP_W_DEFAULT = 255;

  localparam logic [FE_W-1:0] P =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fe_modmul.sv
// Combinational field multiplier: y = a * b mod (2^255 - 19).
//   a, b : 255-bit operands (need not be reduced)
//   y    : canonical product
module fe_modmul
  import modexp_pkg::*;
(
  input  logic [FE_W-1:0] a,
  input  logic [FE_W-1:0] b,
  output logic [FE_W-1:0] y
);

  logic [2*FE_W-1:0] prod;

  assign prod = {{FE_W{1'b0}}, a} * {{FE_W{1'b0}}, b};

  modreduce_255mult u_reduce (
    .x (prod),
    .y (y)
  );

endmodule

// File: rtl/modreduce_255mult.sv
// Reduces a 510-bit product modulo p = 2^255 - 19 to canonical form [0, p-1].
//   x : 510-bit input (any value below 2^510)
//   y : x mod p
// Uses 2^255 == 19 (mod p) twice, then one conditional subtraction of p.
module modreduce_255mult
  import modexp_pkg::*;
(
  input  logic [2*FE_W-1:0] x,
  output logic [FE_W-1:0]   y
);

  // First fold: lo + 19*hi < 2^255 + 19*2^255 < 2^261.
  localparam int unsigned T_W = FE_W + 6;

  logic [T_W-1:0]  fold1;
  logic [FE_W:0]   fold2;
  logic [FE_W:0]   p_ext;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    p_ext = {1'b0, P};
    fold1 = {6'd0, x[FE_W-1:0]} + T_W'(x[2*FE_W-1:FE_W]) * T_W'(19);
    // Second fold: upper 6 bits are below 64, so the sum stays under 2^255 + 1216 < 2p.
    fold2 = {1'b0, fold1[FE_W-1:0]} + (FE_W+1)'(fold1[T_W-1:FE_W]) * (FE_W+1)'(19);
    if (fold2 >= p_ext) begin
      y = FE_W'(fold2 - p_ext);
    end else begin
      y = fold2[FE_W-1:0];
    end
  end

endmodule

// File: rtl/modexp_255_ctrl.sv
// Left-to-right square-and-multiply-always exponentiation modulo 2^255 - 19.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a run (sampled only in IDLE or DONE)
//   base, exp  : operands, captured on an accepted start
//   busy       : high during SQR/MUL
//   done       : one-cycle pulse on entry to DONE
//   result     : (base mod p)^exp mod p, held until the next run completes
// Latency from the start-sampling edge to done is 2*EXP_W+1 cycles.
module modexp_255_ctrl
  import modexp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FE_W-1:0]  base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [FE_W-1:0]  result
);

  localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_e           state_q,  state_d;
  logic [FE_W-1:0]  acc_q,    acc_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [FE_W-1:0]  base_r_q, base_r_d;
  logic [EXP_W-1:0] exp_r_q,  exp_r_d;
  logic [FE_W-1:0]  result_q, result_d;

  logic [FE_W-1:0]  mul_b;
  logic [FE_W-1:0]  mul_y;

  // Squaring reuses the single multiplier with acc on both inputs.
  assign mul_b = (state_q == MUL) ? base_r_q : acc_q;

  fe_modmul u_modmul (
    .a (acc_q),
    .b (mul_b),
    .y (mul_y)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    base_r_d = base_r_q;
    exp_r_d  = exp_r_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_r_d = base;
          exp_r_d  = exp;
          acc_d    = FE_W'(1);
          idx_d    = IDX_W'(EXP_W - 1);
          state_d  = SQR;
        end else begin
          state_d  = IDLE;
        end
      end

      SQR: begin
        acc_d   = mul_y;
        state_d = MUL;
      end

      // The product is always formed so timing does not depend on the exponent;
      // it is only kept when the current exponent bit is set.
      MUL: begin
        if (exp_r_q[idx_q]) begin
          acc_d = mul_y;
        end
        if (idx_q == '0) begin
          result_d = exp_r_q[idx_q] ? mul_y : acc_q;
          state_d  = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SQR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      base_r_q <= '0;
      exp_r_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      base_r_q <= base_r_d;
      exp_r_q  <= exp_r_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == SQR) || (state_q == MUL);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_modexp_255_ctrl.sv
// Self-checking bench for modexp_255_ctrl: directed boundary vectors, start
// handling, mid-run reset and randomized operands against a reference model.
module tb_modexp_255_ctrl;
  import modexp_pkg::*;

  localparam int unsigned EXP_W   = 255;
  localparam int          LAT     = 2 * EXP_W + 1;
  localparam int          LIMIT   = LAT + 40;
  localparam logic [254:0] INV2   =
    255'h3fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff7;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [254:0]     base_i;
  logic [EXP_W-1:0] exp_i;
  logic             busy;
  logic             done;
  logic [254:0]     result;

  int n_vec = 0;
  int n_err = 0;

  modexp_255_ctrl #(.EXP_W(EXP_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base_i),
    .exp    (exp_i),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [254:0] got, input logic [254:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [254:0] rand_fe();
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[254:0];
  endfunction

  // Right-to-left binary exponentiation using plain wide arithmetic.
  function automatic logic [254:0] ref_modexp(input logic [254:0] b, input logic [254:0] e);
    logic [511:0] r, x, pp;
    pp = {257'd0, P};
    r  = 512'd1;
    x  = {257'd0, b} % pp;
    for (int i = 0; i < EXP_W; i++) begin
      if (e[i]) r = (r * x) % pp;
      x = (x * x) % pp;
    end
    return r[254:0];
  endfunction

  // Called at a negedge: presents operands, lets the next edge sample start,
  // then scrambles the inputs to show they are not re-read during the run.
  task automatic launch(input logic [254:0] b, input logic [254:0] e);
    base_i = b;
    exp_i  = e;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    base_i = rand_fe();
    exp_i  = rand_fe();
  endtask

  // Returns at the negedge where done is seen (or the bound expires).
  // lat counts cycles after the start-sampling edge.
  task automatic wait_done(input int poke_at, output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    forever begin
      if (poke_at != 0 && lat == poke_at) begin
        start  = 1'b1;
        base_i = rand_fe();
        exp_i  = rand_fe();
      end else if (poke_at != 0 && lat == poke_at + 1) begin
        start  = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done || lat >= LIMIT) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [254:0] b, input logic [254:0] e,
                           input int poke_at);
    int lat, bc;
    logic [254:0] want;
    want = ref_modexp(b, e);
    launch(b, e);
    wait_done(poke_at, lat, bc);
    check({tag, " result"}, result, want);
    check({tag, " latency"}, 255'(lat), 255'(LAT));
    check({tag, " busy_cycles"}, 255'(bc), 255'(2 * EXP_W));
    @(negedge clk);
    check({tag, " done_width"}, 255'(done), 255'(0));
    check({tag, " result_hold"}, result, want);
  endtask

  logic [254:0] dir_b   [7];
  logic [254:0] dir_e   [7];
  logic [254:0] dir_res [7];

  initial begin
    int lat, bc, dcnt;
    logic [254:0] b1, e1, b2, e2, w1, w2;

    dir_b[0] = 255'd2;   dir_e[0] = 255'd3;   dir_res[0] = 255'd8;
    dir_b[1] = 255'd5;   dir_e[1] = 255'd0;   dir_res[1] = 255'd1;
    dir_b[2] = 255'd0;   dir_e[2] = 255'd0;   dir_res[2] = 255'd1;
    dir_b[3] = 255'd0;   dir_e[3] = 255'd7;   dir_res[3] = 255'd0;
    dir_b[4] = P - 1'b1; dir_e[4] = 255'd2;   dir_res[4] = 255'd1;
    dir_b[5] = P;        dir_e[5] = 255'd5;   dir_res[5] = 255'd0;
    dir_b[6] = 255'd2;   dir_e[6] = P - 2'd2; dir_res[6] = INV2;

    rst_n  = 1'b0;
    start  = 1'b0;
    base_i = '0;
    exp_i  = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   255'(busy), 255'(0));
    check("reset done",   255'(done), 255'(0));
    check("reset result", result, 255'(0));
    rst_n = 1'b1;

    // Directed vectors: fixed expected values and the model must both agree.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      launch(dir_b[i], dir_e[i]);
      wait_done(0, lat, bc);
      check($sformatf("dir%0d result", i), result, dir_res[i]);
      check($sformatf("dir%0d model", i), ref_modexp(dir_b[i], dir_e[i]), dir_res[i]);
      check($sformatf("dir%0d latency", i), 255'(lat), 255'(LAT));
      check($sformatf("dir%0d busy_cycles", i), 255'(bc), 255'(2 * EXP_W));
    end

    // Start pulsed mid-run is ignored.
    @(negedge clk);
    run_check("poke50", rand_fe(), rand_fe(), 50);

    // Back-to-back: start held in the done cycle chains a second run.
    b1 = rand_fe(); e1 = rand_fe(); w1 = ref_modexp(b1, e1);
    b2 = rand_fe(); e2 = rand_fe() >> 200; w2 = ref_modexp(b2, e2);
    @(negedge clk);
    launch(b1, e1);
    wait_done(0, lat, bc);
    check("b2b first result",  result, w1);
    check("b2b first latency", 255'(lat), 255'(LAT));
    launch(b2, e2);
    wait_done(0, lat, bc);
    check("b2b second result",  result, w2);
    check("b2b second latency", 255'(lat), 255'(LAT));

    // Randomized operands with varying exponent bit-lengths.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_check($sformatf("rand%0d", i), rand_fe(), rand_fe() >> $urandom_range(0, 254), 0);
    end

    // Reset one cycle at cycle 100 aborts the run without a done pulse.
    @(negedge clk);
    launch(rand_fe(), rand_fe());
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy",   255'(busy), 255'(0));
    check("abort done",   255'(done), 255'(0));
    check("abort result", result, 255'(0));
    dcnt = 0;
    repeat (LIMIT) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort no_done", 255'(dcnt), 255'(0));
    @(negedge clk);
    launch(255'd3, 255'd4);
    wait_done(0, lat, bc);
    check("post_reset result",  result, 255'd81);
    check("post_reset latency", 255'(lat), 255'(LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
